// File: rtl/btn_debounce_repeat.sv
// Push-button conditioner: two-flop synchroniser, tick-timed lockout windows and press pulses.
// Auto-repeat while held is built only when the macro BTN_AUTOREPEAT_EN is defined.

module btn_debounce_repeat_chk (
  input logic clk,
  input logic rst_n,
  input logic press_pulse,
  input logic btn_level,
  input logic hold_active
);

  no_double_pulse_a: assert property (@(posedge clk) disable iff (!rst_n)
    press_pulse |=> !press_pulse);

  hold_implies_level_a: assert property (@(posedge clk) disable iff (!rst_n)
    hold_active |-> btn_level);

endmodule

module btn_debounce_repeat #(
  parameter int unsigned CLK_HZ        = 100000000,
  parameter int unsigned TICK_HZ       = 1000,
  parameter int unsigned LOCKOUT_TICKS = 200,
  parameter int unsigned HOLD_TICKS    = 500,
  parameter int unsigned REPEAT_TICKS  = 150
) (
  input  logic CLK,
  input  logic RESETn,
  input  logic btn_in,
  output logic press_pulse,
  output logic btn_level,
  output logic hold_active
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [15:0]   LOCK_N    = 16'(LOCKOUT_TICKS);

  if ((DIV * TICK_HZ != CLK_HZ) || (HOLD_TICKS <= LOCKOUT_TICKS) || (REPEAT_TICKS < 1)) begin : g_bad_cfg
    $error("btn_debounce_repeat: invalid timing parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_LOCK_PRESS   = 3'd1,
    S_HELD         = 3'd2,
    S_LOCK_RELEASE = 3'd3
`ifdef BTN_AUTOREPEAT_EN
    ,S_REPEAT      = 3'd4
`endif
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [PW-1:0] presc_q, presc_d, presc_run_s;
  logic [15:0]   tcnt_q, tcnt_d, tcnt_run_s, tcnt_inc_s;
  logic          tick_s, lock_done_s;
  logic          press_pulse_q, press_pulse_d;
  logic          btn_level_q, btn_level_d;
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [15:0] HOLD_N = 16'(HOLD_TICKS);
  localparam logic [15:0] REP_N  = 16'(REPEAT_TICKS);
  logic          hold_done_s, rep_done_s;
  logic          hold_active_q, hold_active_d;
`endif

  // Only the second synchroniser flop is ever looked at by the FSM.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Free-running prescaler and saturating tick count; a window expires on the tick that lands on N.
  always_comb begin
    tick_s     = (presc_q == PRESC_MAX);
    tcnt_inc_s = (tcnt_q == 16'hFFFF) ? tcnt_q : (tcnt_q + 16'd1);
    if (tick_s) begin
      presc_run_s = {PW{1'b0}};
      tcnt_run_s  = tcnt_inc_s;
    end else begin
      presc_run_s = presc_q + PW'(1);
      tcnt_run_s  = tcnt_q;
    end
    lock_done_s = tick_s && (tcnt_inc_s == LOCK_N);
`ifdef BTN_AUTOREPEAT_EN
    hold_done_s = tick_s && (tcnt_inc_s == HOLD_N);
    rep_done_s  = tick_s && (tcnt_inc_s == REP_N);
`endif
  end

  // Next state and next registered outputs; a release always beats a simultaneous expiry.
  always_comb begin
    state_d       = state_q;
    presc_d       = presc_run_s;
    tcnt_d        = tcnt_run_s;
    press_pulse_d = 1'b0;
    btn_level_d   = btn_level_q;
`ifdef BTN_AUTOREPEAT_EN
    hold_active_d = hold_active_q;
`endif
    case (state_q)
      S_IDLE: begin
        presc_d = {PW{1'b0}};
        tcnt_d  = 16'd0;
        if (sync2_q) begin
          state_d       = S_LOCK_PRESS;
          press_pulse_d = 1'b1;
          btn_level_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOCK_PRESS: begin
        if (lock_done_s && sync2_q) begin
          state_d = S_HELD;
        end else if (lock_done_s) begin
          state_d     = S_LOCK_RELEASE;
          presc_d     = {PW{1'b0}};
          tcnt_d      = 16'd0;
          btn_level_d = 1'b0;
        end else begin
          state_d = S_LOCK_PRESS;
        end
      end
      S_HELD: begin
        if (!sync2_q) begin
          state_d     = S_LOCK_RELEASE;
          presc_d     = {PW{1'b0}};
          tcnt_d      = 16'd0;
          btn_level_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        end else if (hold_done_s) begin
          state_d       = S_REPEAT;
          presc_d       = {PW{1'b0}};
          tcnt_d        = 16'd0;
          press_pulse_d = 1'b1;
          hold_active_d = 1'b1;
`endif
        end else begin
          state_d = S_HELD;
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      S_REPEAT: begin
        if (!sync2_q) begin
          state_d       = S_LOCK_RELEASE;
          presc_d       = {PW{1'b0}};
          tcnt_d        = 16'd0;
          btn_level_d   = 1'b0;
          hold_active_d = 1'b0;
        end else if (rep_done_s) begin
          state_d       = S_REPEAT;
          presc_d       = {PW{1'b0}};
          tcnt_d        = 16'd0;
          press_pulse_d = 1'b1;
        end else begin
          state_d = S_REPEAT;
        end
      end
`endif
      S_LOCK_RELEASE: begin
        if (lock_done_s) begin
          state_d = S_IDLE;
          presc_d = {PW{1'b0}};
          tcnt_d  = 16'd0;
        end else begin
          state_d = S_LOCK_RELEASE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        presc_d     = {PW{1'b0}};
        tcnt_d      = 16'd0;
        btn_level_d = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
        hold_active_d = 1'b0;
`endif
      end
    endcase
  end

  // State, timebase and output registers.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q       <= S_IDLE;
      presc_q       <= {PW{1'b0}};
      tcnt_q        <= 16'd0;
      press_pulse_q <= 1'b0;
      btn_level_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      hold_active_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      tcnt_q        <= tcnt_d;
      press_pulse_q <= press_pulse_d;
      btn_level_q   <= btn_level_d;
`ifdef BTN_AUTOREPEAT_EN
      hold_active_q <= hold_active_d;
`endif
    end
  end

  assign press_pulse = press_pulse_q;
  assign btn_level   = btn_level_q;
`ifdef BTN_AUTOREPEAT_EN
  assign hold_active = hold_active_q;
`else
  assign hold_active = 1'b0;
`endif

  btn_debounce_repeat_chk u_chk (
    .clk         (CLK),
    .rst_n       (RESETn),
    .press_pulse (press_pulse_q),
    .btn_level   (btn_level_q),
    .hold_active (hold_active)
  );

endmodule
